alu_dec_adjust: RTL and testbench

- Back end of the ALU adder path: takes the raw binary result of the 8-bit three-input adder (sum, carry out, low-nibble carry) and produces the final accumulator value and flags.
- Binary mode: registers the result and derives flags in one cycle.
- Decimal mode (ADC/SBC with D=1): applies the 65C02 BCD correction over two extra cycles, low nibble then high nibble.
- Sits between the adder and the register file / P-register writeback, with a valid/ready handshake on each side.

---
 rtl/alu_dec_adjust_pkg.sv | 16 +
 rtl/alu_dec_adjust_if.sv | 31 +++
 rtl/alu_dec_adjust_bcd_nibble_fix.sv | 21 ++
 rtl/alu_dec_adjust.sv | 167 ++++++++++++++++
 tb/tb_alu_dec_adjust.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_dec_adjust_pkg.sv
// Shared types and constants for the ALU decimal-adjust back end.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam logic [7:0] ADJ_LO   = 8'h06;
    localparam logic [7:0] ADJ_HI   = 8'h60;
    localparam logic [7:0] HI_LIMIT = 8'h9F;
    localparam logic [3:0] NINE     = 4'h9;

endpackage

// File: rtl/alu_dec_adjust_if.sv
// Adder-to-writeback bus: input handshake + raw adder result, output
// handshake + final accumulator value and flags.
interface alu_dec_adjust_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sum;
    logic       co;
    logic       hc;
    logic       v_in;
    logic       sub;
    logic       dec;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       c;
    logic       z;
    logic       n;
    logic       v;

    // Driver side (adder / writeback stage)
    modport master (
        output in_valid, sum, co, hc, v_in, sub, dec, out_ready,
        input  in_ready, out_valid, result, c, z, n, v
    );

    // Decimal-adjust block side
    modport slave (
        input  in_valid, sum, co, hc, v_in, sub, dec, out_ready,
        output in_ready, out_valid, result, c, z, n, v
    );
endinterface

// File: rtl/alu_dec_adjust_bcd_nibble_fix.sv
// One BCD correction step: add (ADC) or subtract (SBC) a correction constant
// from a 9-bit working value. Subtraction is 8-bit only, so the borrow never
// reaches bit 8; addition exposes its carry in bit 8.
module bcd_nibble_fix (
    input  logic [8:0] val,
    input  logic       sub,
    input  logic       en,
    input  logic [7:0] k,
    output logic [8:0] res
);

    // Apply the correction only when enabled
    always_comb begin
        res = val;
        if (en) begin
            if (sub) res = {1'b0, val[7:0] - k};
            else     res = val + {1'b0, k};
        end
    end

endmodule

// File: rtl/alu_dec_adjust.sv
// ALU decimal-adjust back end: registers the binary adder result and flags,
// or (with ALU_DECIMAL_EN defined) applies 65C02 BCD correction over two
// extra cycles, low nibble first, then high nibble.
// Macro ALU_DECIMAL_EN: when undefined, dec is ignored and LO/HI are not built.
module alu_dec_adjust #(
    parameter logic [7:0] RESET_RESULT = 8'h00,
    parameter logic [3:0] NINE         = 4'h9
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_dec_adjust_if.slave   bus
);
    import alu_pkg::*;

    state_e     state_q, state_d;
    logic [7:0] result_q, result_d;
    logic       c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
    logic       ld;

`ifdef ALU_DECIMAL_EN
    logic [8:0] w_q, w_d;
    logic       co_q, co_d, hc_q, hc_d, vin_q, vin_d, sub_q, sub_d, cx_q, cx_d;
    logic [8:0] fix_in, fix_out;
    logic [7:0] fix_k;
    logic       fix_en;

    // Single correction unit shared by the LO and HI steps
    bcd_nibble_fix u_fix (
        .val (fix_in),
        .sub (sub_q),
        .en  (fix_en),
        .k   (fix_k),
        .res (fix_out)
    );
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= RESET_RESULT;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
`ifdef ALU_DECIMAL_EN
            w_q      <= 9'd0;
            co_q     <= 1'b0;
            hc_q     <= 1'b0;
            vin_q    <= 1'b0;
            sub_q    <= 1'b0;
            cx_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
`ifdef ALU_DECIMAL_EN
            w_q      <= w_d;
            co_q     <= co_d;
            hc_q     <= hc_d;
            vin_q    <= vin_d;
            sub_q    <= sub_d;
            cx_q     <= cx_d;
`endif
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
`ifdef ALU_DECIMAL_EN
                state_d = bus.dec ? LO : OUT;
`else
                state_d = OUT;
`endif
            end
`ifdef ALU_DECIMAL_EN
            LO:   state_d = HI;
            HI:   state_d = OUT;
`endif
            OUT:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture, nibble corrections, result/flag load
    always_comb begin
        result_d = result_q;
        c_d      = c_q;
        v_d      = v_q;
        ld       = 1'b0;
`ifdef ALU_DECIMAL_EN
        w_d    = w_q;
        co_d   = co_q;
        hc_d   = hc_q;
        vin_d  = vin_q;
        sub_d  = sub_q;
        cx_d   = cx_q;
        fix_in = {1'b0, w_q[7:0]};
        fix_k  = ADJ_LO;
        fix_en = 1'b0;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
`ifdef ALU_DECIMAL_EN
                co_d  = bus.co;
                hc_d  = bus.hc;
                vin_d = bus.v_in;
                sub_d = bus.sub;
                if (bus.dec) begin
                    w_d  = {1'b0, bus.sum};
                    cx_d = 1'b0;
                end else begin
                    result_d = bus.sum;
                    c_d      = bus.co;
                    v_d      = bus.v_in;
                    ld       = 1'b1;
                end
`else
                result_d = bus.sum;
                c_d      = bus.co;
                v_d      = bus.v_in;
                ld       = 1'b1;
`endif
            end
`ifdef ALU_DECIMAL_EN
            LO: begin
                fix_k  = ADJ_LO;
                fix_en = sub_q ? !hc_q : (hc_q || (w_q[3:0] > NINE));
                w_d    = fix_out;
                cx_d   = !sub_q && fix_out[8];
            end
            HI: begin
                fix_k    = ADJ_HI;
                fix_en   = sub_q ? !co_q : (co_q || cx_q || (w_q[7:0] > HI_LIMIT));
                w_d      = fix_out;
                result_d = fix_out[7:0];
                c_d      = sub_q ? co_q : fix_en;
                v_d      = vin_q;
                ld       = 1'b1;
            end
`endif
            default: ;
        endcase
        // Z/N only move when a new result is loaded
        z_d = ld ? (result_d == 8'h00) : z_q;
        n_d = ld ? result_d[7]         : n_q;
    end

    // Handshake and output drive
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == OUT);
        bus.result    = result_q;
        bus.c         = c_q;
        bus.z         = z_q;
        bus.n         = n_q;
        bus.v         = v_q;
    end

endmodule

// File: tb/tb_alu_dec_adjust.sv
// Directed bench for alu_dec_adjust: table of vectors plus backpressure and
// mid-operation reset sequences. Expectations follow the build's macro.
module tb_alu_dec_adjust;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_dec_adjust_if bus ();

    alu_dec_adjust #(.RESET_RESULT(8'h00), .NINE(4'h9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] sum;
        logic       co, hc, v_in, sub, dec;
        logic [7:0] exp_res;
        logic       exp_c, exp_v;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Build a vector; dec_res/dec_c are the hand-computed BCD answers, used
    // only when decimal mode is built and dec=1.
    function automatic vec_t mk(input logic [7:0] s, input logic co, hc, vi, sb, dc,
                                input logic [7:0] dec_res, input logic dec_c);
        vec_t t;
        t.sum = s; t.co = co; t.hc = hc; t.v_in = vi; t.sub = sb; t.dec = dc;
        t.exp_res = s; t.exp_c = co; t.exp_v = vi; t.exp_lat = 1;
`ifdef ALU_DECIMAL_EN
        if (dc) begin
            t.exp_res = dec_res; t.exp_c = dec_c; t.exp_lat = 3;
        end
`endif
        return t;
    endfunction

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.sum = 8'h00; bus.co = 1'b0; bus.hc = 1'b0;
        bus.v_in = 1'b0; bus.sub = 1'b0; bus.dec = 1'b0;
    endtask

    // Present one vector in IDLE and wait (bounded) for out_valid
    task automatic apply(input vec_t t, input string tag, output int lat);
        @(negedge clk);
        bus.sum = t.sum; bus.co = t.co; bus.hc = t.hc; bus.v_in = t.v_in;
        bus.sub = t.sub; bus.dec = t.dec; bus.in_valid = 1'b1;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        drive_idle();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin lat = k; break; end
        end
    endtask

    task automatic check_out(input vec_t t, input string tag, input int lat);
        chk({tag, "_lat"},    lat,          t.exp_lat);
        chk({tag, "_result"}, bus.result,   t.exp_res);
        chk({tag, "_c"},      bus.c,        t.exp_c);
        chk({tag, "_z"},      bus.z,        (t.exp_res == 8'h00));
        chk({tag, "_n"},      bus.n,        t.exp_res[7]);
        chk({tag, "_v"},      bus.v,        t.exp_v);
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_back_idle"}, bus.in_ready, 1);
    endtask

    initial begin
        int lat;
        vec_t t;
        logic [7:0] held;

        vecs[0] = mk(8'h80, 1, 0, 1, 0, 0, 8'h80, 1);  // binary ADC
        vecs[1] = mk(8'h00, 0, 0, 0, 0, 0, 8'h00, 0);  // binary zero
        vecs[2] = mk(8'h9E, 0, 0, 0, 0, 1, 8'h04, 1);  // 58+46
        vecs[3] = mk(8'h9A, 0, 0, 0, 0, 1, 8'h00, 1);  // 99+01
        vecs[4] = mk(8'h0F, 1, 0, 0, 1, 1, 8'h09, 1);  // 10-01
        vecs[5] = mk(8'hFF, 0, 0, 0, 1, 1, 8'h99, 0);  // 00-01
        vecs[6] = mk(8'h3C, 0, 0, 1, 0, 1, 8'h42, 0);  // 15+27, v passthrough
        vecs[7] = mk(8'h12, 0, 1, 0, 0, 1, 8'h18, 0);  // 09+09, half carry
        vecs[8] = mk(8'h30, 1, 1, 0, 1, 1, 8'h30, 1);  // 50-20, no correction
        vecs[9] = mk(8'h7F, 0, 0, 1, 1, 0, 8'h7F, 0);  // binary SBC

        drive_idle();
        bus.out_ready = 1'b0;
        #12;
        chk("rst_result",    bus.result,    8'h00);
        chk("rst_flags",     {bus.c, bus.z, bus.n, bus.v}, 4'b0000);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready",  bus.in_ready,  1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(vecs[i], tag, lat);
            check_out(vecs[i], tag, lat);
            release_out(tag);
        end

        // Backpressure: hold OUT, pulse inputs that must be ignored
        t = vecs[0];
        apply(t, "bp", lat);
        check_out(t, "bp", lat);
        held = bus.result;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = k[0];
            bus.sum = 8'h11; bus.dec = 1'b0;
            @(negedge clk);
            chk("bp_hold_result", bus.result,    held);
            chk("bp_hold_flags",  {bus.c, bus.n, bus.v}, {t.exp_c, t.exp_res[7], t.exp_v});
            chk("bp_in_ready",    bus.in_ready,  0);
            chk("bp_out_valid",   bus.out_valid, 1);
        end
        drive_idle();
        release_out("bp");
        @(negedge clk);
        chk("bp_no_accept",   bus.out_valid, 0);
        chk("bp_keep_result", bus.result,    held);

        // Reset during the low-nibble step discards the operation
        @(negedge clk);
        bus.sum = 8'h9E; bus.dec = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_result",    bus.result,    8'h00);
        chk("mid_rst_flags",     {bus.c, bus.z, bus.n, bus.v}, 4'b0000);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready",  bus.in_ready,  1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_idle", {bus.out_valid, bus.in_ready}, 2'b01);
        end

        // Decimal 58+46 again after reset
        apply(vecs[2], "again", lat);
        check_out(vecs[2], "again", lat);
        release_out("again");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
